// File: rtl/amba_dec_pkg.sv
// Shared types and constants for the AES AMBA slave front end: command classes,
// decoder FSM states and the address-phase classifier.
package amba_dec_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_KEYW,
    CMD_DATW,
    CMD_DATR,
    CMD_BAD
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ISSUE,
    BUSY,
    STALL,
    RELEASE,
    ERR,
    ERRWAIT
  } dec_state_t;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_128     = 3'b100;
  localparam int         BUSY_W        = 4;

  // Only full 128-bit accesses to the two registers are legal; the key is write-only.
  function automatic cmd_t classify(input logic        hwrite,
                                    input logic [15:0] haddr,
                                    input logic [2:0]  hsize,
                                    input logic [15:0] key_addr,
                                    input logic [15:0] data_addr);
    cmd_t c;
    c = CMD_BAD;
    if (hsize == HSIZE_128) begin
      if (hwrite && (haddr == key_addr))       c = CMD_KEYW;
      else if (hwrite && (haddr == data_addr)) c = CMD_DATW;
      else if (!hwrite && (haddr == data_addr)) c = CMD_DATR;
    end
    return c;
  endfunction

endpackage

// File: rtl/amba_slave_decoder_hclk_edge_sync.sv
// Brings the slow bus clock into the core clock domain and turns its edges into
// registered single-cycle rise/fall pulses.
module hclk_edge_sync
  import amba_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hclk_async,
  output logic hclk_rise,
  output logic hclk_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      hclk_rise <= 1'b0;
      hclk_fall <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], hclk_async};
      hist_q    <= sync_bit;
      hclk_rise <= sync_bit & ~hist_q;
      hclk_fall <= ~sync_bit & hist_q;
    end
  end

endmodule

// File: rtl/amba_slave_decoder.sv
// AHB address-phase decoder for the AES slave: turns bus transfers into one-cycle
// command strobes, error requests and wait-state requests for the SRAM interface FSM.
module amba_slave_decoder
  import amba_dec_pkg::*;
#(
  parameter logic [15:0] KEY_ADDR    = 16'h0000,
  parameter logic [15:0] DATA_ADDR   = 16'h0020,
  parameter int          SYNC_STAGES = 2,
  parameter int          KEY_BUSY    = 5,
  parameter int          DWR_BUSY    = 3,
  parameter int          DRD_BUSY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HCLK,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [15:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  output logic        HCLK_rise,
  output logic        HCLK_fall,
  output logic        writek_enable,
  output logic        writed_enable,
  output logic        readd_enable,
  output logic        hresp_error,
  output logic        hready_enable,
  output dec_state_t  dbg_state
);

  dec_state_t          state_q, state_n;
  cmd_t                cmd_q, cmd_n, cap_cmd;
  cmd_t                pend_cmd_q, pend_cmd_n;
  logic                pend_valid_q, pend_valid_n;
  logic [BUSY_W-1:0]   busy_q, busy_n;
  logic                capture;

  hclk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .hclk_async (HCLK),
    .hclk_rise  (HCLK_rise),
    .hclk_fall  (HCLK_fall)
  );

  // Handshake: a transfer is valid only on an HCLK_rise cycle with HSEL, HTRANS
  // NONSEQ/SEQ and HREADY (bus ready) all high; the only back-pressure this block
  // applies is hready_enable, raised while a queued transfer waits in STALL.
  assign capture = HCLK_rise && HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign cap_cmd = classify(HWRITE, HADDR, HSIZE, KEY_ADDR, DATA_ADDR);
  assign dbg_state = state_q;

  function automatic logic [BUSY_W-1:0] busy_load(input cmd_t c);
    case (c)
      CMD_KEYW: return BUSY_W'(KEY_BUSY);
      CMD_DATW: return BUSY_W'(DWR_BUSY);
      CMD_DATR: return BUSY_W'(DRD_BUSY);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    state_n      = state_q;
    cmd_n        = cmd_q;
    pend_valid_n = pend_valid_q;
    pend_cmd_n   = pend_cmd_q;
    busy_n       = busy_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          cmd_n   = cap_cmd;
          state_n = (cap_cmd == CMD_BAD) ? ERR : ADDR;
        end
      end
      ADDR: begin
        if (HCLK_fall) state_n = ISSUE;
      end
      ISSUE: begin
        busy_n  = busy_load(cmd_q);
        state_n = BUSY;
        if (capture) begin
          pend_valid_n = 1'b1;
          pend_cmd_n   = cap_cmd;
        end
      end
      BUSY: begin
        // A later capture simply overwrites the slot; the clock ratio rules it out.
        if (capture) begin
          pend_valid_n = 1'b1;
          pend_cmd_n   = cap_cmd;
        end
        if (busy_q == '0) state_n = pend_valid_n ? STALL : IDLE;
        else              busy_n  = busy_q - BUSY_W'(1);
      end
      STALL: begin
        if (HCLK_fall) state_n = RELEASE;
      end
      RELEASE: begin
        cmd_n        = pend_cmd_q;
        pend_valid_n = 1'b0;
        pend_cmd_n   = CMD_NONE;
        state_n      = (pend_cmd_q == CMD_BAD) ? ERR : ISSUE;
      end
      ERR: begin
        state_n = ERRWAIT;
      end
      ERRWAIT: begin
        if (HCLK_fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= CMD_NONE;
      pend_valid_q  <= 1'b0;
      pend_cmd_q    <= CMD_NONE;
      busy_q        <= '0;
      writek_enable <= 1'b0;
      writed_enable <= 1'b0;
      readd_enable  <= 1'b0;
      hresp_error   <= 1'b0;
      hready_enable <= 1'b0;
    end else begin
      state_q       <= state_n;
      cmd_q         <= cmd_n;
      pend_valid_q  <= pend_valid_n;
      pend_cmd_q    <= pend_cmd_n;
      busy_q        <= busy_n;
      writek_enable <= (state_n == ISSUE) && (cmd_n == CMD_KEYW);
      writed_enable <= (state_n == ISSUE) && (cmd_n == CMD_DATW);
      readd_enable  <= (state_n == ISSUE) && (cmd_n == CMD_DATR);
      hresp_error   <= (state_n == ERR);
      hready_enable <= (state_n == STALL);
    end
  end

endmodule

// File: tb/tb_amba_slave_decoder.sv
// Directed bench for amba_slave_decoder: reset, HCLK edge detection, command
// decode, error classes, ignored transfers and a back-to-back stall sequence.
module tb_amba_slave_decoder;
  import amba_dec_pkg::*;

  localparam int KEY_BUSY = 5;
  localparam int DWR_BUSY = 3;
  localparam int DRD_BUSY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        HCLK;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [15:0] HADDR;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic        HCLK_rise, HCLK_fall;
  logic        writek_enable, writed_enable, readd_enable, hresp_error, hready_enable;
  dec_state_t  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int hclk_half = 8;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int ob_c0 = 0;
  int cap_cyc = 0;

  // Per-cycle trace: {hready, hresp, readd, writed, writek}
  logic [4:0]  tr_out [64];
  dec_state_t  tr_st  [64];
  logic [1:0]  tr_rf  [64];

  amba_slave_decoder #(
    .KEY_ADDR(16'h0000), .DATA_ADDR(16'h0020), .SYNC_STAGES(2),
    .KEY_BUSY(KEY_BUSY), .DWR_BUSY(DWR_BUSY), .DRD_BUSY(DRD_BUSY)
  ) dut (
    .clk(clk), .rst(rst), .HCLK(HCLK), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HADDR(HADDR), .HSIZE(HSIZE), .HREADY(HREADY),
    .HCLK_rise(HCLK_rise), .HCLK_fall(HCLK_fall),
    .writek_enable(writek_enable), .writed_enable(writed_enable),
    .readd_enable(readd_enable), .hresp_error(hresp_error),
    .hready_enable(hready_enable), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // HCLK toggles on clk falling edges every hclk_half cycles
  task automatic hclk_gen();
    int hcnt = 0;
    forever begin
      @(negedge clk);
      if (hcnt >= hclk_half - 1) begin
        hcnt = 0;
        HCLK = ~HCLK;
        if (HCLK) rise_cyc = cyc;
        else      fall_cyc = cyc;
      end else begin
        hcnt++;
      end
    end
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) ob_c0 = cyc;
      tr_out[i] = {hready_enable, hresp_error, readd_enable, writed_enable, writek_enable};
      tr_st[i]  = dbg_state;
      tr_rf[i]  = {HCLK_fall, HCLK_rise};
    end
  endtask

  // Present an address phase until the decoder's capture cycle, then go idle.
  task automatic drive_xfer(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [15:0] addr, input logic [2:0] size);
    int waited = 0;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    do begin
      @(negedge clk);
      waited++;
    end while (HCLK_rise !== 1'b1 && waited < 40);
    if (HCLK_rise !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL drive_timeout: no HCLK_rise within %0d clk, expected one", waited);
    end
    cap_cyc = cyc;
    @(posedge clk);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  function automatic int count_bit(input int b, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tr_out[i][b] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_idx(input int b, input int n);
    for (int i = 0; i < n; i++) if (tr_out[i][b] === 1'b1) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [6:0] outs;
    int w = 0;
    rst = 1'b1; HCLK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {HCLK_rise, HCLK_fall, writek_enable, writed_enable, readd_enable,
              hresp_error, hready_enable};
      tests_run++;
      if (outs !== 7'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %b expected 0000000", i, outs);
      end
      HCLK = (i == 0);
    end
    rst = 1'b0;
    fork hclk_gen(); join_none
    do begin
      @(negedge clk);
      w++;
    end while (HCLK_rise !== 1'b1 && w < 20);
    tests_run++;
    if (HCLK_rise !== 1'b1 || (cyc - rise_cyc) != 3) begin
      tests_failed++;
      $display("FAIL reset_first_rise: rise=%b latency %0d expected 1 with latency 3",
               HCLK_rise, cyc - rise_cyc);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_edge_detect();
    int w = 0;
    int both = 0;
    int p;
    do begin
      @(negedge clk);
      w++;
      if (HCLK_rise === 1'b1 && HCLK_fall === 1'b1) both++;
    end while (HCLK_rise !== 1'b1 && w < 40);
    p = cyc;
    tests_run++;
    if (HCLK_rise !== 1'b1 || (cyc - rise_cyc) != 3) begin
      tests_failed++;
      $display("FAIL edge_rise_latency: rise=%b latency %0d expected 1 with 3", HCLK_rise, cyc - rise_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (HCLK_rise !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_rise_width: got %b expected 0 one clk later", HCLK_rise);
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
      if (HCLK_rise === 1'b1 && HCLK_fall === 1'b1) both++;
    end while (HCLK_fall !== 1'b1 && w < 20);
    tests_run++;
    if (HCLK_fall !== 1'b1 || (cyc - p) != 8) begin
      tests_failed++;
      $display("FAIL edge_rise_to_fall: fall=%b spacing %0d expected 1 with 8", HCLK_fall, cyc - p);
    end
    tests_run++;
    if ((cyc - fall_cyc) != 3) begin
      tests_failed++;
      $display("FAIL edge_fall_latency: got %0d expected 3", cyc - fall_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (HCLK_fall !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_fall_width: got %b expected 0", HCLK_fall);
    end
    tests_run++;
    if (both != 0) begin
      tests_failed++;
      $display("FAIL edge_overlap: got %0d cycles with both pulses expected 0", both);
    end
  endtask

  task automatic test_key_write();
    int cap, wk, others;
    fork
      observe(40);
      drive_xfer(1'b1, 2'b10, 1'b1, 16'h0000, 3'b100);
    join
    cap = cap_cyc - ob_c0;
    wk = first_idx(0, 40);
    others = count_bit(1, 40) + count_bit(2, 40) + count_bit(3, 40) + count_bit(4, 40);
    tests_run++;
    if (count_bit(0, 40) != 1) begin
      tests_failed++;
      $display("FAIL keyw_count: got %0d writek pulses expected 1", count_bit(0, 40));
    end
    tests_run++;
    if (others != 0) begin
      tests_failed++;
      $display("FAIL keyw_other_strobes: got %0d expected 0", others);
    end
    tests_run++;
    if (tr_st[cap+1] !== ADDR) begin
      tests_failed++;
      $display("FAIL keyw_addr_state: got %0d expected %0d", tr_st[cap+1], ADDR);
    end
    tests_run++;
    if (tr_rf[wk-1][1] !== 1'b1 || (wk - cap) != 9) begin
      tests_failed++;
      $display("FAIL keyw_after_fall: fall_before=%b offset %0d expected 1 and 9",
               tr_rf[wk-1][1], wk - cap);
    end
    tests_run++;
    if (tr_st[wk+KEY_BUSY+1] !== BUSY || tr_st[wk+KEY_BUSY+2] !== IDLE) begin
      tests_failed++;
      $display("FAIL keyw_busy_len: got %0d,%0d expected %0d,%0d",
               tr_st[wk+KEY_BUSY+1], tr_st[wk+KEY_BUSY+2], BUSY, IDLE);
    end
  endtask

  task automatic test_data_read();
    int rd, others;
    fork
      observe(40);
      drive_xfer(1'b1, 2'b10, 1'b0, 16'h0020, 3'b100);
    join
    rd = first_idx(2, 40);
    others = count_bit(0, 40) + count_bit(1, 40) + count_bit(3, 40) + count_bit(4, 40);
    tests_run++;
    if (count_bit(2, 40) != 1) begin
      tests_failed++;
      $display("FAIL datr_count: got %0d readd pulses expected 1", count_bit(2, 40));
    end
    tests_run++;
    if (others != 0) begin
      tests_failed++;
      $display("FAIL datr_other_strobes: got %0d expected 0", others);
    end
    tests_run++;
    if (tr_st[rd+DRD_BUSY+1] !== BUSY || tr_st[rd+DRD_BUSY+2] !== IDLE) begin
      tests_failed++;
      $display("FAIL datr_busy_len: got %0d,%0d expected %0d,%0d",
               tr_st[rd+DRD_BUSY+1], tr_st[rd+DRD_BUSY+2], BUSY, IDLE);
    end
  endtask

  task automatic test_data_write_seq();
    int wd, others;
    fork
      observe(40);
      drive_xfer(1'b1, 2'b11, 1'b1, 16'h0020, 3'b100);
    join
    wd = first_idx(1, 40);
    others = count_bit(0, 40) + count_bit(2, 40) + count_bit(3, 40) + count_bit(4, 40);
    tests_run++;
    if (count_bit(1, 40) != 1 || others != 0) begin
      tests_failed++;
      $display("FAIL datw_strobes: got writed %0d others %0d expected 1 and 0",
               count_bit(1, 40), others);
    end
    tests_run++;
    if (tr_st[wd+DWR_BUSY+1] !== BUSY || tr_st[wd+DWR_BUSY+2] !== IDLE) begin
      tests_failed++;
      $display("FAIL datw_busy_len: got %0d,%0d expected %0d,%0d",
               tr_st[wd+DWR_BUSY+1], tr_st[wd+DWR_BUSY+2], BUSY, IDLE);
    end
  endtask

  task automatic test_errors();
    logic        wrs   [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] addrs [3] = '{16'h0000, 16'h0010, 16'h0020};
    logic [2:0]  sizes [3] = '{3'b100, 3'b100, 3'b010};
    int cap, en;
    for (int k = 0; k < 3; k++) begin
      fork
        observe(40);
        drive_xfer(1'b1, 2'b10, wrs[k], addrs[k], sizes[k]);
      join
      cap = cap_cyc - ob_c0;
      en = count_bit(0, 40) + count_bit(1, 40) + count_bit(2, 40) + count_bit(4, 40);
      tests_run++;
      if (count_bit(3, 40) != 1 || tr_out[cap+1][3] !== 1'b1) begin
        tests_failed++;
        $display("FAIL err%0d_hresp: got %0d pulses, at cap+1=%b expected 1 and 1",
                 k, count_bit(3, 40), tr_out[cap+1][3]);
      end
      tests_run++;
      if (en != 0) begin
        tests_failed++;
        $display("FAIL err%0d_enables: got %0d expected 0", k, en);
      end
      tests_run++;
      if (tr_st[cap+8] !== ERRWAIT || tr_st[cap+9] !== IDLE) begin
        tests_failed++;
        $display("FAIL err%0d_return: got %0d,%0d expected %0d,%0d",
                 k, tr_st[cap+8], tr_st[cap+9], ERRWAIT, IDLE);
      end
    end
  endtask

  task automatic test_ignored();
    int act, busy_cyc;
    for (int k = 0; k < 3; k++) begin
      act = 0; busy_cyc = 0;
      HREADY = (k != 2);
      fork
        observe(24);
        drive_xfer(k != 0, (k == 1) ? 2'b01 : 2'b10, 1'b1, 16'h0000, 3'b100);
      join
      HREADY = 1'b1;
      for (int i = 0; i < 24; i++) begin
        if (tr_out[i] !== 5'd0) act++;
        if (tr_st[i] !== IDLE) busy_cyc++;
      end
      tests_run++;
      if (act != 0 || busy_cyc != 0) begin
        tests_failed++;
        $display("FAIL ignored%0d: got %0d active, %0d non-idle cycles expected 0 and 0",
                 k, act, busy_cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1, wk, hr, wd;
    hclk_half = 2;
    repeat (12) @(negedge clk);
    fork
      observe(60);
      begin
        drive_xfer(1'b1, 2'b10, 1'b1, 16'h0000, 3'b100);
        c1 = cap_cyc;
        drive_xfer(1'b1, 2'b10, 1'b1, 16'h0020, 3'b100);
      end
    join
    c1 = c1 - ob_c0;
    wk = first_idx(0, 60);
    hr = first_idx(4, 60);
    wd = first_idx(1, 60);
    tests_run++;
    if (count_bit(0, 60) != 1 || count_bit(1, 60) != 1 ||
        count_bit(2, 60) != 0 || count_bit(3, 60) != 0) begin
      tests_failed++;
      $display("FAIL b2b_counts: got k%0d d%0d r%0d e%0d expected k1 d1 r0 e0",
               count_bit(0, 60), count_bit(1, 60), count_bit(2, 60), count_bit(3, 60));
    end
    tests_run++;
    if ((wk - c1) != 3 || (hr - c1) != 10 || count_bit(4, 60) != 1) begin
      tests_failed++;
      $display("FAIL b2b_stall: writek at +%0d hready at +%0d x%0d expected +3, +10 x1",
               wk - c1, hr - c1, count_bit(4, 60));
    end
    tests_run++;
    if (tr_out[hr+1] !== 5'd0 || tr_st[hr+1] !== RELEASE) begin
      tests_failed++;
      $display("FAIL b2b_release: got out %b state %0d expected 00000 and %0d",
               tr_out[hr+1], tr_st[hr+1], RELEASE);
    end
    tests_run++;
    if ((wd - hr) != 2 || tr_out[wd] !== 5'b00010) begin
      tests_failed++;
      $display("FAIL b2b_writed: offset %0d out %b expected 2 and 00010", wd - hr, tr_out[wd]);
    end
    tests_run++;
    if (tr_st[59] !== IDLE) begin
      tests_failed++;
      $display("FAIL b2b_final_state: got %0d expected %0d", tr_st[59], IDLE);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 16'h0000;
    HSIZE = 3'b000; HREADY = 1'b1; HCLK = 1'b0; rst = 1'b1;
    test_reset();
    test_edge_detect();
    test_key_write();
    test_data_read();
    test_data_write_seq();
    test_errors();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
